// File: rtl/mem_io_bridge.sv
// Data-bus bridge: routes datapath loads/stores to external RAM or a small memory-mapped I/O bank
// (LEDs, switches, buttons, compare timer). Define BTN_DEBOUNCE_EN to build the button debouncers.
module mem_io_bridge #(
    parameter int RAM_WORDS  = 256,
    parameter int SW_W       = 10,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_write,
    input  logic [31:0]                  address,
    input  logic [31:0]                  write_data,
    output logic [31:0]                  read_data,
    output logic                         ram_we,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    input  logic [SW_W-1:0]              sw,
    input  logic [3:0]                   btn,
    output logic [15:0]                  led
);

    localparam int          AW         = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
    localparam logic [31:0] ADDR_LED   = 32'h0000_1000;
    localparam logic [31:0] ADDR_SW    = 32'h0000_1004;
    localparam logic [31:0] ADDR_BTN   = 32'h0000_1008;
    localparam logic [31:0] ADDR_TCNT  = 32'h0000_100C;
    localparam logic [31:0] ADDR_TCMP  = 32'h0000_1010;
    localparam logic [31:0] ADDR_TCTRL = 32'h0000_1014;

    logic            ram_hit;
    logic            wr_led, wr_tcount, wr_tcmp, wr_tctrl;
    logic            match_now;
    logic [31:0]     tcount, tcmp;
    logic            t_en, t_autoclr, t_match;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic [3:0]      btn_s1, btn_s2, btn_val;

    assign ram_hit   = address < RAM_BYTES;
    assign ram_we    = ram_hit & mem_write;
    assign ram_addr  = address[2 +: AW];
    assign ram_wdata = write_data;

    // RAM wins any overlap with the I/O window, so I/O strobes are gated by ram_hit
    assign wr_led    = mem_write & ~ram_hit & (address == ADDR_LED);
    assign wr_tcount = mem_write & ~ram_hit & (address == ADDR_TCNT);
    assign wr_tcmp   = mem_write & ~ram_hit & (address == ADDR_TCMP);
    assign wr_tctrl  = mem_write & ~ram_hit & (address == ADDR_TCTRL);

    assign match_now = t_en & (tcount == tcmp);

    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = ram_rdata;
        end else begin
            case (address)
                ADDR_LED:   read_data = {16'h0000, led};
                ADDR_SW:    read_data = 32'(sw_s2);
                ADDR_BTN:   read_data = {28'h0, btn_val};
                ADDR_TCNT:  read_data = tcount;
                ADDR_TCMP:  read_data = tcmp;
                ADDR_TCTRL: read_data = {29'h0, t_match, t_autoclr, t_en};
                default:    read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led       <= '0;
            tcount    <= '0;
            tcmp      <= '0;
            t_en      <= 1'b0;
            t_autoclr <= 1'b0;
            t_match   <= 1'b0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            btn_s1    <= '0;
            btn_s2    <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            if (wr_led)  led  <= write_data[15:0];
            if (wr_tcmp) tcmp <= write_data;
            if (wr_tctrl) begin
                t_en      <= write_data[0];
                t_autoclr <= write_data[1];
            end
            if (wr_tcount)                   tcount <= write_data;
            else if (match_now && t_autoclr) tcount <= '0;
            else if (t_en)                   tcount <= tcount + 32'd1;
            // A fresh match outranks a simultaneous write-1-clear
            if (match_now)                         t_match <= 1'b1;
            else if (wr_tctrl && write_data[2])    t_match <= 1'b0;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    typedef enum logic {STABLE, COUNTING} deb_state_t;
    localparam int            CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    for (genvar i = 0; i < 4; i++) begin : g_deb
        deb_state_t    state;
        logic [CW-1:0] cnt;
        logic          accepted;

        assign btn_val[i] = accepted;

        // The first differing cycle already counts, so acceptance lands DEB_CYCLES cycles after the synced change
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state    <= STABLE;
                cnt      <= '0;
                accepted <= 1'b0;
            end else begin
                case (state)
                    STABLE: begin
                        cnt <= '0;
                        if (btn_s2[i] != accepted) begin
                            if (DEB_CYCLES <= 1) begin
                                accepted <= btn_s2[i];
                            end else begin
                                state <= COUNTING;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    COUNTING: begin
                        if (btn_s2[i] == accepted) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            accepted <= btn_s2[i];
                            state    <= STABLE;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
`else
    assign btn_val = btn_s2;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed steps, expectations queued then compared on DUT output.
module tb_mem_io_bridge;

    localparam int RAM_WORDS = 256;
    localparam int SW_W      = 10;
    localparam int DEB       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [SW_W-1:0] sw;
    logic [3:0]  btn;
    logic [15:0] led;

    logic [31:0] ram_mem [RAM_WORDS];

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_io_bridge #(
        .RAM_WORDS (RAM_WORDS),
        .SW_W      (SW_W),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_write (mem_write),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led)
    );

    always #5 clk = ~clk;

    // External RAM stand-in: synchronous write, combinational read
    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    assign ram_rdata = ram_mem[ram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic we);
        address    = a;
        write_data = d;
        mem_write  = we;
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL scoreboard_empty: observed %h, nothing expected", observed);
            return;
        end
        e = sb.pop_front();
        assert (observed === e.value)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(a, d, 1'b1);
        step();
        applyStimulus(32'h0000_2000, 32'h0, 1'b0);
    endtask

    task automatic readCheck(input logic [31:0] a, input string tag, input logic [31:0] exp);
        applyStimulus(a, 32'h0, 1'b0);
        pushExpect(tag, exp);
        #1;
        checkOutput(read_data);
    endtask

    task automatic sigCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        pushExpect(tag, exp);
        checkOutput(obs);
    endtask

    initial begin
        logic [31:0] tseq [6];
        tseq[0] = 1; tseq[1] = 2; tseq[2] = 3; tseq[3] = 4; tseq[4] = 5; tseq[5] = 0;

        rst = 1'b0;
        sw  = '0;
        btn = '0;
        applyStimulus(32'h0000_2000, 32'h0, 1'b0);
        #2;
        sigCheck("reset_led", 32'(led), 32'h0);
        readCheck(32'h0000_1014, "reset_tctrl", 32'h0);
        readCheck(32'h0000_100C, "reset_tcount", 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // RAM region store and boundaries
        applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        #1;
        sigCheck("ram_we_store", 32'(ram_we), 32'h1);
        sigCheck("ram_addr_store", 32'(ram_addr), 32'h4);
        sigCheck("ram_wdata_store", ram_wdata, 32'hDEAD_BEEF);
        step();
        readCheck(32'h0000_0010, "ram_load", 32'hDEAD_BEEF);
        applyStimulus(32'h0000_03FC, 32'h1, 1'b1);
        #1;
        sigCheck("ram_we_last_word", 32'(ram_we), 32'h1);
        sigCheck("ram_addr_last_word", 32'(ram_addr), 32'hFF);
        applyStimulus(32'h0000_0400, 32'h1, 1'b1);
        #1;
        sigCheck("ram_we_past_end", 32'(ram_we), 32'h0);
        applyStimulus(32'h0000_2000, 32'h1, 1'b1);
        #1;
        sigCheck("ram_we_unmapped", 32'(ram_we), 32'h0);
        sigCheck("read_unmapped", read_data, 32'h0);
        step();
        applyStimulus(32'h0000_2000, 32'h0, 1'b0);

        // LED, SW, exact I/O decode
        busWrite(32'h0000_1000, 32'h0000_ABCD);
        sigCheck("led_out", 32'(led), 32'h0000_ABCD);
        readCheck(32'h0000_1000, "led_read", 32'h0000_ABCD);
        readCheck(32'h0000_1001, "misaligned_io", 32'h0);
        sw = 10'h2A5;
        step();
        readCheck(32'h0000_1004, "sw_one_edge", 32'h0);
        step();
        readCheck(32'h0000_1004, "sw_two_edges", 32'h0000_02A5);
        busWrite(32'h0000_1004, 32'h0000_0001);
        readCheck(32'h0000_1004, "sw_ro", 32'h0000_02A5);

        // Timer with autoclear
        busWrite(32'h0000_1010, 32'd5);
        busWrite(32'h0000_100C, 32'd0);
        busWrite(32'h0000_1014, 32'h3);
        readCheck(32'h0000_100C, "tcount_start", 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            readCheck(32'h0000_100C, $sformatf("tcount_seq%0d", k), tseq[k]);
            if (k == 4) readCheck(32'h0000_1014, "tctrl_pre_match", 32'h3);
            if (k == 5) readCheck(32'h0000_1014, "tctrl_match", 32'h7);
        end
        busWrite(32'h0000_1014, 32'h7);
        readCheck(32'h0000_1014, "tctrl_w1c", 32'h3);
        readCheck(32'h0000_100C, "tcount_after_clear", 32'd1);
        repeat (4) step();
        readCheck(32'h0000_100C, "tcount_at_cmp", 32'd5);
        busWrite(32'h0000_1014, 32'h7);
        readCheck(32'h0000_1014, "match_set_beats_clear", 32'h7);
        readCheck(32'h0000_100C, "tcount_autoclr", 32'h0);

        // Wrap without autoclear
        busWrite(32'h0000_1014, 32'h1);
        busWrite(32'h0000_100C, 32'hFFFF_FFFF);
        readCheck(32'h0000_100C, "tcount_written", 32'hFFFF_FFFF);
        step();
        readCheck(32'h0000_100C, "tcount_wrap", 32'h0);
        busWrite(32'h0000_1014, 32'h5);
        readCheck(32'h0000_1014, "tctrl_en_only", 32'h1);

        // Buttons
`ifdef BTN_DEBOUNCE_EN
        btn = 4'b0001;
        repeat (3) step();
        btn = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            readCheck(32'h0000_1008, $sformatf("btn_pulse%0d", k), 32'h0);
        end
        btn = 4'b0001;
        repeat (5) step();
        readCheck(32'h0000_1008, "btn_press_early", 32'h0);
        step();
        readCheck(32'h0000_1008, "btn_press_accept", 32'h1);
        btn = 4'b0000;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e == 3) btn = 4'b0001;
            if (e == 5) btn = 4'b0000;
            readCheck(32'h0000_1008, $sformatf("btn_release_e%0d", e), (e >= 11) ? 32'h0 : 32'h1);
        end
`else
        btn = 4'b1010;
        step();
        readCheck(32'h0000_1008, "btn_one_edge", 32'h0);
        step();
        readCheck(32'h0000_1008, "btn_two_edges", 32'hA);
        btn = 4'b0000;
        step();
        readCheck(32'h0000_1008, "btn_rel_one_edge", 32'hA);
        step();
        readCheck(32'h0000_1008, "btn_rel_two_edges", 32'h0);
`endif

        // Asynchronous reset mid-count
        btn = 4'b0001;
        repeat (7) step();
        readCheck(32'h0000_1008, "btn_before_reset", 32'h1);
        #2;
        rst = 1'b0;
        #1;
        sigCheck("async_led", 32'(led), 32'h0);
        readCheck(32'h0000_100C, "async_tcount", 32'h0);
        readCheck(32'h0000_1014, "async_tctrl", 32'h0);
        readCheck(32'h0000_1008, "async_btn", 32'h0);
        applyStimulus(32'h0000_0010, 32'h1, 1'b1);
        #1;
        sigCheck("reset_ram_we_decode", 32'(ram_we), 32'h1);
        applyStimulus(32'h0000_2000, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Data-bus bridge directly downstream of the single-cycle processor datapath. Consumes the datapath's ALU-computed address, store data and the control unit's memory-write strobe; routes each access either to the external data RAM or to a small bank of memory-mapped I/O registers; returns `read_data` to the datapath in the same cycle. The I/O registers cover LEDs, synchronised switches, buttons (debounced when configured) and a 32-bit compare timer with a sticky match flag.

## Interface
- `RAM_WORDS`, 256: data RAM depth in 32-bit words; RAM region is byte addresses `0` to `RAM_WORDS*4-1`.
- `SW_W`, 10: switch input width.
- `DEB_CYCLES`, 500000: cycles of stable input required to accept a button change.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_write`  in  1  store strobe from the control unit.
- `address`  in  32  byte address from the datapath ALU; bits [1:0] ignored (word access only).
- `write_data`  in  32  store data from the datapath.
- `read_data`  out  32  load data to the datapath, combinational.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  $clog2(RAM_WORDS)  RAM word address, equal to `address[2 +: $clog2(RAM_WORDS)]`.
- `ram_wdata`  out  32  equal to `write_data`.
- `ram_rdata`  in  32  RAM read data, combinational.
- `sw`  in  SW_W  asynchronous switch inputs.
- `btn`  in  4  asynchronous button inputs, active-high.
- `led`  out  16  LED register output.

## Operation
- Decode:
  - RAM hit when `address < RAM_WORDS*4`: `ram_we = mem_write`; `read_data = ram_rdata`.
  - Otherwise `ram_we = 0`.
  - I/O decode is on `address[31:0]` exactly (word aligned).
  - Unmapped reads return 0; unmapped writes are ignored.
- I/O map:
  - `0x1000` LED, RW, bits [15:0].
  - `0x1004` SW, RO: 2-flop synchronised `sw`, zero-extended.
  - `0x1008` BTN, RO, bits [3:0].
  - `0x100C` TCOUNT, RW.
  - `0x1010` TCMP, RW.
  - `0x1014` TCTRL:
    - bit0 `en`, RW.
    - bit1 `autoclr`, RW.
    - bit2 `match`, sticky; write 1 to clear, write 0 has no effect.
    - Other bits read 0.
- Writes to RO registers are ignored.
- Timer:
  - When `en`=1, TCOUNT increments by 1 each cycle, wrapping `0xFFFFFFFF -> 0`.
  - Match condition: `en`=1 and TCOUNT == TCMP, evaluated on the pre-edge value. On match, `match` is set; if `autoclr`=1, the next TCOUNT is 0 instead of TCOUNT+1.
  - Precedence on TCOUNT: CPU write > autoclear > increment.
  - Precedence on `match`: a set in the same cycle as a write-1-clear wins (flag stays 1).
- Button debounce, per bit: 2-flop synchroniser feeding an FSM.
  - STABLE: synced input == accepted value; counter = 0.
  - COUNTING: synced input != accepted value; counter increments each cycle. Input returning to the accepted value -> STABLE, counter = 0. Counter reaching `DEB_CYCLES-1` -> accept the new value, go to STABLE.
- Reset values, all asynchronous on `rst`=0:
  - LED, TCOUNT, TCMP, TCTRL, all synchroniser flops, accepted button values: 0.
  - All FSMs in STABLE.
  - Outputs: `led`=0, `ram_we` = decode of inputs (RAM region and `mem_write`), `read_data` = decode result.

## Timing
- Loads are zero-latency: `read_data` is valid in the same cycle as `address`, as the single-cycle datapath requires. Loads have no side effects, including on `match`.
- Stores are registered at the rising edge where `mem_write`=1. The new value is readable in the following cycle.
- Switch latency: a change on `sw` is visible in SW 2 edges later.
- Button latency: 2 synchroniser edges plus `DEB_CYCLES` stable cycles.
- Reset deasserted mid-count restarts from 0; no partially debounced value survives reset.

## Configuration
- `BTN_DEBOUNCE_EN` defined: debounce FSMs and counters are built as described.
- `BTN_DEBOUNCE_EN` undefined: BTN returns the 2-flop synchronised `btn` directly (2-cycle latency); `DEB_CYCLES` is unused and no counter logic is built.

## Test plan
- Store `0xDEADBEEF` to `0x0000_0010` -> `ram_we`=1, `ram_addr`=4 and `ram_wdata`=`0xDEADBEEF` in that cycle. Load from `0x2000` -> `read_data`=0, `ram_we`=0.
- Store `0x0000ABCD` to `0x1000` -> `led`=`0xABCD` after the edge. Drive `sw`=`0x2A5` -> SW reads `0x2A5` exactly 2 edges later.
- TCMP=5, TCTRL=`0x3`, TCOUNT=0 -> TCOUNT sequence 1,2,3,4,5,0 with `match`=1 from the cycle after the compare. Write `0x7` to TCTRL -> `match` cleared, `en` and `autoclr` kept.
- Write-1-clear to TCTRL in the same cycle as a match -> `match` remains 1. Write TCOUNT=`0xFFFFFFFF` with `en`=1, `autoclr`=0 -> next cycle reads 0.
- With `BTN_DEBOUNCE_EN` defined and `DEB_CYCLES`=4:
  - A 3-cycle pulse on `btn[0]` -> BTN stays 0.
  - A held press -> BTN reads 1 after 2+4 edges.
  - Release with a 2-cycle glitch back to 1 -> restarts the count.
- Assert `rst`=0 mid-count with `led` nonzero -> `led`, TCOUNT, TCTRL and BTN read 0 immediately, without waiting for a clock edge.
